// File: rtl/mem_stage.sv
// Y86-64 memory stage: performs the data-memory access for one executed
// instruction at a time and hands a registered result to write-back.
module mem_stage #(
  parameter logic [63:0] ADDR_LIMIT = 64'd8192,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [3:0]  e_icode,
  input  logic [2:0]  e_stat,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [63:0] e_valP,
  input  logic        e_Cnd,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        m_valid,
  input  logic        w_ready,
  output logic [3:0]  m_icode,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM,
  output logic        m_Cnd,
  output logic [3:0]  m_dstE,
  output logic [3:0]  m_dstM,
  output logic        halted
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          halted_q, halted_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [3:0]    icode_q, icode_d;
  logic [2:0]    stat_q, stat_d;
  logic [63:0]   valE_q, valE_d;
  logic [63:0]   valM_q, valM_d;
  logic          cnd_q, cnd_d;
  logic [3:0]    dstE_q, dstE_d;
  logic [3:0]    dstM_q, dstM_d;

  logic          acc_s, we_s, rd_s, legal_s, start_acc_s, xfer_s, tmo_expire_s;
  logic [63:0]   addr_s, wdata_s;
  logic [2:0]    cap_stat_s;

  // Decode the access an incoming instruction needs and whether it is legal.
  always_comb begin
    acc_s   = 1'b0;
    we_s    = 1'b0;
    rd_s    = 1'b0;
    addr_s  = e_valE;
    wdata_s = e_valA;
    case (e_icode)
      IC_RMMOVQ: begin acc_s = 1'b1; we_s = 1'b1; end
      IC_MRMOVQ: begin acc_s = 1'b1; rd_s = 1'b1; end
      IC_CALL:   begin acc_s = 1'b1; we_s = 1'b1; wdata_s = e_valP; end
      IC_RET:    begin acc_s = 1'b1; rd_s = 1'b1; addr_s = e_valA; end
      IC_PUSHQ:  begin acc_s = 1'b1; we_s = 1'b1; end
      IC_POPQ:   begin acc_s = 1'b1; rd_s = 1'b1; addr_s = e_valA; end
      default:   begin acc_s = 1'b0; end
    endcase
    // Comparing against LIMIT-8 also rejects addresses that would wrap past 2^64.
    legal_s     = (addr_s <= (ADDR_LIMIT - 64'd8));
    start_acc_s = (e_stat == STAT_AOK) && acc_s && legal_s;
    if (e_stat != STAT_AOK) begin
      cap_stat_s = e_stat;
    end else if (acc_s && !legal_s) begin
      cap_stat_s = STAT_ADR;
    end else begin
      cap_stat_s = e_stat;
    end
    xfer_s       = e_valid && e_ready;
    tmo_expire_s = (tmo_q == TW'(TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; an ack on the expiry edge wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_s) begin
          state_d = start_acc_s ? S_ACCESS : S_FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_ack || tmo_expire_s) begin
          state_d = S_FULL;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_FULL: begin
        if (w_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FULL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    e_ready = (state_q == S_IDLE) && !halted_q;
    mem_req = (state_q == S_ACCESS);
    m_valid = (state_q == S_FULL);
  end

  // Datapath next-state: capture on accept, complete on ack/timeout, halt on retire.
  always_comb begin
    halted_d = halted_q;
    tmo_d    = tmo_q;
    rd_d     = rd_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    icode_d  = icode_q;
    stat_d   = stat_q;
    valE_d   = valE_q;
    valM_d   = valM_q;
    cnd_d    = cnd_q;
    dstE_d   = dstE_q;
    dstM_d   = dstM_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (xfer_s) begin
          icode_d = e_icode;
          stat_d  = cap_stat_s;
          valE_d  = e_valE;
          valM_d  = 64'd0;
          cnd_d   = e_Cnd;
          dstE_d  = e_dstE;
          dstM_d  = (cap_stat_s == STAT_AOK) ? e_dstM : REG_NONE;
          rd_d    = rd_s;
          if (start_acc_s) begin
            we_d    = we_s;
            addr_d  = addr_s;
            wdata_d = wdata_s;
          end else begin
            we_d    = we_q;
          end
        end else begin
          tmo_d = '0;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          tmo_d = '0;
          if (rd_q) begin
            valM_d = mem_rdata;
          end else begin
            valM_d = valM_q;
          end
          if (mem_err) begin
            stat_d = STAT_ADR;
            dstM_d = REG_NONE;
          end else begin
            stat_d = STAT_AOK;
          end
        end else if (tmo_expire_s) begin
          tmo_d  = '0;
          stat_d = STAT_ADR;
          dstM_d = REG_NONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FULL: begin
        if (w_ready && (stat_q != STAT_AOK)) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end
      default: begin
        tmo_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      tmo_q    <= '0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      icode_q  <= 4'd0;
      stat_q   <= 3'd0;
      valE_q   <= 64'd0;
      valM_q   <= 64'd0;
      cnd_q    <= 1'b0;
      dstE_q   <= 4'd0;
      dstM_q   <= 4'd0;
    end else begin
      halted_q <= halted_d;
      tmo_q    <= tmo_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      icode_q  <= icode_d;
      stat_q   <= stat_d;
      valE_q   <= valE_d;
      valM_q   <= valM_d;
      cnd_q    <= cnd_d;
      dstE_q   <= dstE_d;
      dstM_q   <= dstM_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m_icode   = icode_q;
  assign m_stat    = stat_q;
  assign m_valE    = valE_q;
  assign m_valM    = valM_q;
  assign m_Cnd     = cnd_q;
  assign m_dstE    = dstE_q;
  assign m_dstM    = dstM_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  localparam logic [63:0] LIMIT = 64'd8192;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic e_valid = 1'b0, e_ready;
  logic [3:0] e_icode = 4'd0;
  logic [2:0] e_stat = 3'd1;
  logic [63:0] e_valE = 64'd0, e_valA = 64'd0, e_valP = 64'd0;
  logic e_Cnd = 1'b0;
  logic [3:0] e_dstE = 4'hF, e_dstM = 4'hF;
  logic mem_req, mem_we, mem_ack = 1'b0, mem_err = 1'b0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = 64'd0;
  logic m_valid, w_ready = 1'b0, m_Cnd, halted;
  logic [3:0] m_icode, m_dstE, m_dstM;
  logic [2:0] m_stat;
  logic [63:0] m_valE, m_valM;

  int n_checks = 0;
  int n_err = 0;
  bit exp_halt = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .e_valid(e_valid), .e_ready(e_ready), .e_icode(e_icode), .e_stat(e_stat),
    .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP), .e_Cnd(e_Cnd),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_valid(m_valid), .w_ready(w_ready), .m_icode(m_icode), .m_stat(m_stat),
    .m_valE(m_valE), .m_valM(m_valM), .m_Cnd(m_Cnd), .m_dstE(m_dstE),
    .m_dstM(m_dstM), .halted(halted)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural rules: which instructions touch memory, where, and the final status.
  task automatic model(input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] vE, input logic [63:0] vA, input logic [63:0] vP,
                       input int ack_dly, input bit err,
                       output bit acc, output bit wr, output logic [63:0] addr,
                       output logic [63:0] wd, output logic [2:0] fstat, output int reqc);
    bit touches, legal;
    touches = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    wr      = ic inside {4'h4, 4'h8, 4'hA};
    addr    = (ic inside {4'h9, 4'hB}) ? vA : vE;
    wd      = (ic == 4'h8) ? vP : vA;
    legal   = ({1'b0, addr} + 65'd8) <= {1'b0, LIMIT};
    acc     = 1'b0;
    reqc    = 0;
    if (st != 3'd1) fstat = st;
    else if (!touches) fstat = 3'd1;
    else if (!legal) fstat = 3'd3;
    else begin
      acc = 1'b1;
      if (ack_dly < TMO) begin
        reqc  = ack_dly + 1;
        fstat = err ? 3'd3 : 3'd1;
      end else begin
        reqc  = TMO;
        fstat = 3'd3;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_halt = 1'b0;
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_m_valid", m_valid, 1'b0);
    check_val("rst_halted", halted, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_mem_addr", mem_addr, 64'd0);
    check_val("rst_mem_wdata", mem_wdata, 64'd0);
    check_val("rst_m_fields", {m_valE, m_icode, m_stat, m_Cnd, m_dstE, m_dstM}, 64'd0);
    check_val("rst_m_valM", m_valM, 64'd0);
    check_val("rst_e_ready", e_ready, 1'b1);
  endtask

  task automatic halted_probe();
    e_valid = 1'b1; e_icode = 4'h5; e_stat = 3'd1; e_valE = 64'h80;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("halt_e_ready", e_ready, 1'b0);
      check_val("halt_no_req", mem_req, 1'b0);
      check_val("halt_no_valid", m_valid, 1'b0);
    end
    e_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] vE,
                           input logic [63:0] vA, input logic [63:0] vP, input logic cnd,
                           input logic [3:0] dE, input logic [3:0] dM, input int ack_dly,
                           input bit err, input logic [63:0] rd, input int hold);
    bit acc, wr, addr_ok;
    logic [63:0] addr, wd, exp_valm;
    logic [2:0] fs;
    int reqc, reqcnt, guard;
    model(ic, st, vE, vA, vP, ack_dly, err, acc, wr, addr, wd, fs, reqc);
    check_val("e_ready_idle", e_ready, 1'b1);
    e_valid = 1'b1; e_icode = ic; e_stat = st; e_valE = vE; e_valA = vA;
    e_valP = vP; e_Cnd = cnd; e_dstE = dE; e_dstM = dM;
    @(posedge clk); #1;
    e_valid = 1'b0;
    e_valE = 64'($urandom); e_valA = 64'($urandom); e_dstM = 4'($urandom);
    check_val("e_ready_busy", e_ready, 1'b0);
    if (acc) begin
      check_val("req_start", mem_req, 1'b1);
      check_val("req_we", mem_we, wr);
      check_val("req_addr", mem_addr, addr);
      if (wr) check_val("req_wdata", mem_wdata, wd);
      reqcnt = 0; guard = 0; addr_ok = 1'b1;
      while (m_valid !== 1'b1 && guard < 40) begin
        if (mem_req === 1'b1) begin
          if (mem_addr !== addr || mem_we !== wr) addr_ok = 1'b0;
          mem_ack = (reqcnt == ack_dly);
          mem_rdata = rd; mem_err = err;
          reqcnt++;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = {$urandom, $urandom};
        guard++;
      end
      check_val("req_cycles", reqcnt, reqc);
      check_val("valid_latency", guard, reqc);
      check_val("req_stable", addr_ok, 1'b1);
      check_val("req_dropped", mem_req, 1'b0);
    end else begin
      check_val("no_req", mem_req, 1'b0);
    end
    exp_valm = (acc && !wr && ack_dly < TMO) ? rd : 64'd0;
    check_val("m_valid", m_valid, 1'b1);
    check_val("m_stat", m_stat, fs);
    if (!(acc && err && ack_dly < TMO)) check_val("m_valM", m_valM, exp_valm);
    check_val("m_valE", m_valE, vE);
    check_val("m_icode", m_icode, ic);
    check_val("m_Cnd", m_Cnd, cnd);
    check_val("m_dstE", m_dstE, dE);
    check_val("m_dstM", m_dstM, (fs == 3'd1) ? dM : 4'hF);
    for (int k = 0; k < hold; k++) begin
      mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check_val("hold_valid", m_valid, 1'b1);
      check_val("hold_valE", m_valE, vE);
      check_val("hold_stat", m_stat, fs);
      check_val("hold_e_ready", e_ready, 1'b0);
      check_val("hold_no_req", mem_req, 1'b0);
      if (!(acc && err && ack_dly < TMO)) check_val("hold_valM", m_valM, exp_valm);
    end
    w_ready = 1'b1;
    @(posedge clk); #1;
    w_ready = 1'b0;
    if (fs != 3'd1) exp_halt = 1'b1;
    check_val("retire_valid", m_valid, 1'b0);
    check_val("halted", halted, exp_halt);
    check_val("e_ready_next", e_ready, !exp_halt);
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return LIMIT - 64'd8;
      1: return LIMIT - 64'd7;
      2: return 64'hFFFF_FFFF_FFFF_FFFC;
      3: return {$urandom, $urandom};
      default: return 64'($urandom_range(0, 8184));
    endcase
  endfunction

  initial begin
    logic [3:0] ic;
    logic [2:0] st;
    int dly;
    do_reset();

    run_instr(4'h5, 3'd1, 64'h100, 64'd0, 64'd0, 1'b0, 4'hF, 4'h3, 2, 1'b0, 64'hDEADBEEF, 0);
    run_instr(4'hA, 3'd1, 64'h1F8, 64'h55, 64'd0, 1'b0, 4'h4, 4'hF, 1, 1'b0, 64'd0, 0);
    run_instr(4'h8, 3'd1, 64'h1F0, 64'd0, 64'h40, 1'b0, 4'h4, 4'hF, 0, 1'b0, 64'd0, 0);
    run_instr(4'h6, 3'd1, 64'h7, 64'h3, 64'd0, 1'b1, 4'h2, 4'hF, 0, 1'b0, 64'd0, 5);
    run_instr(4'h3, 3'd1, 64'h12, 64'd0, 64'd0, 1'b0, 4'h1, 4'hF, 0, 1'b0, 64'd0, 0);
    run_instr(4'hB, 3'd1, 64'h0, LIMIT - 64'd8, 64'd0, 1'b0, 4'h4, 4'h5, 15, 1'b0, 64'h1234, 0);

    run_instr(4'h4, 3'd1, LIMIT - 64'd4, 64'h9, 64'd0, 1'b0, 4'hF, 4'hF, 0, 1'b0, 64'd0, 0);
    halted_probe();
    do_reset();
    run_instr(4'h5, 3'd1, 64'h300, 64'd0, 64'd0, 1'b0, 4'hF, 4'h2, 99, 1'b0, 64'd0, 0);
    do_reset();
    run_instr(4'h9, 3'd1, 64'd0, 64'h400, 64'd0, 1'b0, 4'h4, 4'h7, 1, 1'b1, 64'h77, 0);
    do_reset();

    // Reset in the middle of an outstanding read, then a late ack.
    e_valid = 1'b1; e_icode = 4'h5; e_stat = 3'd1; e_valE = 64'h200; e_dstM = 4'h1;
    @(posedge clk); #1;
    e_valid = 1'b0;
    check_val("mid_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_req", mem_req, 1'b0);
    check_val("mid_rst_valid", m_valid, 1'b0);
    check_val("mid_rst_addr", mem_addr, 64'd0);
    check_val("mid_rst_valE", m_valE, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'hCAFE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("late_ack_valid", m_valid, 1'b0);
      check_val("late_ack_req", mem_req, 1'b0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 60; i++) begin
      ic = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      case ($urandom_range(0, 7))
        0: dly = 99;
        1: dly = 15;
        default: dly = $urandom_range(0, 4);
      endcase
      run_instr(ic, st, pick_addr(), pick_addr(), {$urandom, $urandom}, 1'($urandom),
                4'($urandom), 4'($urandom), dly, ($urandom_range(0, 9) == 0),
                {$urandom, $urandom}, $urandom_range(0, 2));
      if (exp_halt) begin
        halted_probe();
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
